// File: rtl/base_bus_ctrl_if.sv
// CPU-side single-word request port of the BaseRAM/UART bus sequencer.
interface base_bus_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  be_n_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;

  modport master (output req_i, we_i, addr_i, be_n_i, wdata_i, input rdata_o, ack_o);
  modport slave  (input req_i, we_i, addr_i, be_n_i, wdata_i, output rdata_o, ack_o);
endinterface

// File: rtl/base_bus_ctrl.sv
// Sequencer for the shared BaseRAM data bus, whose low byte also carries the CPLD UART.
// Decodes one CPU request at a time into an SRAM access, UART transfer or UART status read.
module base_bus_ctrl #(
  parameter int unsigned RAM_WAIT   = 2,
  parameter int unsigned UART_PULSE = 2
) (
  input  logic        clk,
  input  logic        rst,
  base_bus_ctrl_if.slave cpu,
  inout  wire  [31:0] base_ram_data,
  output logic [19:0] base_ram_addr,
  output logic [3:0]  base_ram_be_n,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        uart_dataready,
  input  logic        uart_tbre,
  input  logic        uart_tsre
);

  localparam logic [31:0] UART_DATA_ADDR = 32'hBFD0_03F8;
  localparam logic [31:0] UART_STAT_ADDR = 32'hBFD0_03FC;
  localparam int unsigned CNT_MAX    = (RAM_WAIT > UART_PULSE) ? RAM_WAIT : UART_PULSE;
  localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned WR_HOLD_AT = (RAM_WAIT > 1) ? RAM_WAIT - 2 : 0;
  localparam int unsigned TX_MASK    = 2;
  localparam int unsigned MASK_W     = $clog2(TX_MASK);

  typedef enum logic [3:0] {
    IDLE, RAM_RD, RAM_WR, U_RD, U_WR_SETUP, U_WR_PULSE, U_WR_HOLD, U_WAIT_TX, DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               tx_pending;
  logic [MASK_W-1:0]  tx_mask;
  logic               bus_oe;
  logic [31:0]        bus_dout;

  assign base_ram_data = bus_oe ? bus_dout : 32'hzzzz_zzzz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      tx_pending    <= 1'b0;
      tx_mask       <= '0;
      bus_oe        <= 1'b0;
      bus_dout      <= '0;
      base_ram_addr <= '0;
      base_ram_be_n <= 4'hF;
      base_ram_ce_n <= 1'b1;
      base_ram_oe_n <= 1'b1;
      base_ram_we_n <= 1'b1;
      uart_rdn      <= 1'b1;
      uart_wrn      <= 1'b1;
      cpu.ack_o     <= 1'b0;
      cpu.rdata_o   <= '0;
    end else begin
      cpu.ack_o <= 1'b0;

      // Stale tbre/tsre are ignored for a short window after each UART write
      if (tx_mask != '0)
        tx_mask <= tx_mask - MASK_W'(1);
      else if (tx_pending && uart_tbre && uart_tsre)
        tx_pending <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (cpu.req_i) begin
            if (cpu.addr_i == UART_STAT_ADDR) begin
              if (!cpu.we_i)
                cpu.rdata_o <= {30'h0, uart_dataready, ~tx_pending};
              cpu.ack_o <= 1'b1;
              state     <= DONE;
            end else if (cpu.addr_i == UART_DATA_ADDR) begin
              if (!cpu.we_i) begin
                uart_rdn <= 1'b0;
                state    <= U_RD;
              end else if (tx_pending) begin
                state <= U_WAIT_TX;
              end else begin
                bus_oe   <= 1'b1;
                bus_dout <= cpu.wdata_i;
                state    <= U_WR_SETUP;
              end
            end else begin
              base_ram_addr <= cpu.addr_i[21:2];
              base_ram_ce_n <= 1'b0;
              if (cpu.we_i) begin
                base_ram_we_n <= 1'b0;
                base_ram_be_n <= cpu.be_n_i;
                bus_oe        <= 1'b1;
                bus_dout      <= cpu.wdata_i;
                state         <= RAM_WR;
              end else begin
                base_ram_oe_n <= 1'b0;
                base_ram_be_n <= 4'h0;
                state         <= RAM_RD;
              end
            end
          end
        end

        RAM_RD: begin
          if (cnt == CNT_W'(RAM_WAIT - 1)) begin
            cpu.rdata_o   <= base_ram_data;
            base_ram_ce_n <= 1'b1;
            base_ram_oe_n <= 1'b1;
            base_ram_be_n <= 4'hF;
            cpu.ack_o     <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // we_n rises one cycle before the end so data is held past the strobe
        RAM_WR: begin
          if (cnt == CNT_W'(RAM_WAIT - 1)) begin
            base_ram_ce_n <= 1'b1;
            base_ram_we_n <= 1'b1;
            base_ram_be_n <= 4'hF;
            bus_oe        <= 1'b0;
            cpu.ack_o     <= 1'b1;
            state         <= DONE;
          end else begin
            if (cnt == CNT_W'(WR_HOLD_AT))
              base_ram_we_n <= 1'b1;
            cnt <= cnt + CNT_W'(1);
          end
        end

        U_RD: begin
          if (cnt == CNT_W'(UART_PULSE - 1)) begin
            cpu.rdata_o <= {24'h0, base_ram_data[7:0]};
            uart_rdn    <= 1'b1;
            cpu.ack_o   <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        U_WAIT_TX: begin
          if (!tx_pending) begin
            bus_oe   <= 1'b1;
            bus_dout <= cpu.wdata_i;
            state    <= U_WR_SETUP;
          end
        end

        U_WR_SETUP: begin
          cnt      <= '0;
          uart_wrn <= 1'b0;
          state    <= U_WR_PULSE;
        end

        U_WR_PULSE: begin
          if (cnt == CNT_W'(UART_PULSE - 1)) begin
            uart_wrn <= 1'b1;
            state    <= U_WR_HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        U_WR_HOLD: begin
          bus_oe     <= 1'b0;
          tx_pending <= 1'b1;
          tx_mask    <= MASK_W'(TX_MASK - 1);
          cpu.ack_o  <= 1'b1;
          state      <= DONE;
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_base_bus_ctrl.sv
// Directed bench for base_bus_ctrl with an SRAM model and a CPLD UART model on the shared bus.
module tb_base_bus_ctrl;
  localparam logic [31:0] UDATA = 32'hBFD0_03F8;
  localparam logic [31:0] USTAT = 32'hBFD0_03FC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [31:0] base_ram_data;
  logic [19:0] base_ram_addr;
  logic [3:0]  base_ram_be_n;
  logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
  logic        uart_rdn, uart_wrn;
  logic        uart_dataready = 1'b0;
  logic        uart_tbre = 1'b1;
  logic        uart_tsre = 1'b1;
  logic [7:0]  uart_byte = 8'h00;

  base_bus_ctrl_if bif ();

  base_bus_ctrl #(.RAM_WAIT(2), .UART_PULSE(2)) dut (
    .clk(clk), .rst(rst), .cpu(bif),
    .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr), .base_ram_be_n(base_ram_be_n),
    .base_ram_ce_n(base_ram_ce_n), .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn), .uart_dataready(uart_dataready),
    .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
  );

  always #5 clk = ~clk;

  // SRAM and UART models driving the shared bus
  logic [31:0] sram_mem [0:15];
  assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n) ? sram_mem[base_ram_addr[3:0]] :
                         (!uart_rdn ? {24'hA5A5A5, uart_byte} : 32'hzzzz_zzzz);

  always @(posedge clk)
    if (!base_ram_ce_n && !base_ram_we_n)
      for (int b = 0; b < 4; b++)
        if (!base_ram_be_n[b]) sram_mem[base_ram_addr[3:0]][8*b +: 8] <= base_ram_data[8*b +: 8];

  int wrn_low = 0, rdn_low = 0, we_low = 0, ce_low = 0, overlap_viol = 0, drive_viol = 0;
  logic [7:0] last_wr_byte = 8'h00;
  always @(negedge clk) begin
    if (!uart_wrn) begin wrn_low++; last_wr_byte = base_ram_data[7:0]; end
    if (!uart_rdn) rdn_low++;
    if (!base_ram_we_n) we_low++;
    if (!base_ram_ce_n) ce_low++;
    if (!base_ram_ce_n && (!uart_rdn || !uart_wrn)) overlap_viol++;
    if (dut.bus_oe && (!base_ram_oe_n || !uart_rdn)) drive_viol++;
  end

  int total = 0, bad = 0;
  int lat, lat_s, stall_bad, w0, r0, we0, c0;
  logic [31:0] rd;
  logic [31:0] exp_mem [0:7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Issue one request; lat counts clocks from the IDLE sample edge to the edge that sees ack
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be_n, output int l, output logic [31:0] r);
    bit got = 0;
    @(posedge clk); #1;
    bif.req_i = 1'b1; bif.we_i = we; bif.addr_i = addr; bif.wdata_i = wd; bif.be_n_i = be_n;
    @(posedge clk);
    l = 999; r = 32'hx;
    for (int k = 1; k <= 200 && !got; k++) begin
      @(negedge clk);
      if (bif.ack_o) begin got = 1; l = k; r = bif.rdata_o; end
      else @(posedge clk);
    end
    bif.req_i = 1'b0;
  endtask

  task automatic snap();
    w0 = wrn_low; r0 = rdn_low; we0 = we_low; c0 = ce_low;
  endtask

  initial begin
    bif.req_i = 1'b0; bif.we_i = 1'b0; bif.addr_i = '0; bif.wdata_i = '0; bif.be_n_i = 4'hF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", 32'(bif.ack_o), 0);
    chk("rst_rdata", bif.rdata_o, 0);
    chk("rst_strobes", 32'({base_ram_ce_n, base_ram_oe_n, base_ram_we_n, uart_rdn, uart_wrn}), 32'h1F);
    chk("rst_be_n", 32'(base_ram_be_n), 32'hF);
    chk("rst_addr", 32'(base_ram_addr), 0);
    chk("rst_bus_oe", 32'(dut.bus_oe), 0);

    // RAM write then read back
    snap();
    do_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'h0, lat, rd);
    chk("ramwr_lat", 32'(lat), 3);
    chk("ramwr_addr", 32'(base_ram_addr), 32'h4);
    chk("ramwr_we_low", 32'(we_low - we0), 1);
    chk("ramwr_ce_low", 32'(ce_low - c0), 2);
    do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, lat, rd);
    chk("ramrd_lat", 32'(lat), 3);
    chk("ramrd_data", rd, 32'hDEAD_BEEF);
    do_req(1'b1, 32'h8000_0010, 32'h1122_3344, 4'b1010, lat, rd);
    do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, lat, rd);
    chk("ramrd_partial", rd, 32'hDE22_BE44);

    // UART write with stale-high flags; the mask keeps tx busy right after
    snap();
    do_req(1'b1, UDATA, 32'h0000_0041, 4'hF, lat, rd);
    chk("uwr_lat", 32'(lat), 5);
    chk("uwr_wrn_low", 32'(wrn_low - w0), 2);
    chk("uwr_ce_low", 32'(ce_low - c0), 0);
    chk("uwr_byte", 32'(last_wr_byte), 32'h41);
    do_req(1'b0, USTAT, 32'h0, 4'hF, lat, rd);
    chk("stat_lat", 32'(lat), 1);
    chk("stat_masked", rd, 32'h0);
    do_req(1'b0, USTAT, 32'h0, 4'hF, lat, rd);
    chk("stat_ready", rd, 32'h1);

    // UART write with flags low: busy until the flags rise
    uart_tbre = 1'b0; uart_tsre = 1'b0;
    do_req(1'b1, UDATA, 32'h0000_0042, 4'hF, lat, rd);
    repeat (5) @(posedge clk);
    do_req(1'b0, USTAT, 32'h0, 4'hF, lat, rd);
    chk("stat_busy", rd, 32'h0);
    uart_tbre = 1'b1; uart_tsre = 1'b1;
    repeat (3) @(posedge clk);
    do_req(1'b0, USTAT, 32'h0, 4'hF, lat, rd);
    chk("stat_after_tx", rd, 32'h1);

    // Second write while tx is pending stalls without touching the bus
    uart_tbre = 1'b0; uart_tsre = 1'b0;
    do_req(1'b1, UDATA, 32'h0000_0044, 4'hF, lat, rd);
    snap();
    fork
      do_req(1'b1, UDATA, 32'h0000_0045, 4'hF, lat_s, rd);
      begin
        stall_bad = 0;
        repeat (20) begin
          @(negedge clk);
          if (!uart_wrn || dut.bus_oe) stall_bad++;
        end
        uart_tbre = 1'b1; uart_tsre = 1'b1;
      end
    join
    chk("stall_quiet", 32'(stall_bad), 0);
    chk("stall_lat_gt20", 32'(lat_s > 20), 1);
    chk("stall_wrn_low", 32'(wrn_low - w0), 2);
    chk("stall_byte", 32'(last_wr_byte), 32'h45);

    // UART read with data ready
    uart_dataready = 1'b1; uart_byte = 8'h5A;
    repeat (5) @(posedge clk);
    do_req(1'b0, USTAT, 32'h0, 4'hF, lat, rd);
    chk("stat_rx", rd, 32'h3);
    snap();
    do_req(1'b0, UDATA, 32'h0, 4'hF, lat, rd);
    chk("urd_lat", 32'(lat), 3);
    chk("urd_data", rd, 32'h0000_005A);
    chk("urd_rdn_low", 32'(rdn_low - r0), 2);
    chk("urd_ce_low", 32'(ce_low - c0), 0);
    snap();
    do_req(1'b1, USTAT, 32'hFFFF_FFFF, 4'hF, lat, rd);
    chk("statwr_lat", 32'(lat), 1);
    chk("statwr_no_strobe", 32'((wrn_low - w0) + (ce_low - c0)), 0);

    // Reset during U_WR_PULSE
    @(posedge clk); #1;
    bif.req_i = 1'b1; bif.we_i = 1'b1; bif.addr_i = UDATA; bif.wdata_i = 32'h77;
    repeat (2) @(posedge clk); #1;
    chk("pre_rst_wrn", 32'(uart_wrn), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_uwr_strobes", 32'({base_ram_ce_n, base_ram_oe_n, base_ram_we_n, uart_rdn, uart_wrn}), 32'h1F);
    chk("rst_uwr_bus", 32'(dut.bus_oe), 0);
    chk("rst_uwr_ack", 32'(bif.ack_o), 0);
    bif.req_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Reset during RAM_WR
    @(posedge clk); #1;
    bif.req_i = 1'b1; bif.we_i = 1'b1; bif.addr_i = 32'h8000_0020; bif.wdata_i = 32'h1234_5678;
    bif.be_n_i = 4'h0;
    @(posedge clk); #1;
    chk("pre_rst_we", 32'(base_ram_we_n), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_rwr_strobes", 32'({base_ram_ce_n, base_ram_oe_n, base_ram_we_n, uart_rdn, uart_wrn}), 32'h1F);
    chk("rst_rwr_bus", 32'(dut.bus_oe), 0);
    chk("rst_rwr_ack", 32'(bif.ack_o), 0);
    bif.req_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, lat, rd);
    chk("post_rst_lat", 32'(lat), 3);
    chk("post_rst_data", rd, 32'hDE22_BE44);

    // Mixed traffic against a shadow memory
    for (int i = 0; i < 8; i++) begin
      exp_mem[i] = $urandom;
      do_req(1'b1, 32'h8000_0000 + 32'(i * 4), exp_mem[i], 4'h0, lat, rd);
    end
    for (int n = 0; n < 30; n++) begin
      int op, idx;
      logic [31:0] d;
      logic [3:0] be;
      op = $urandom_range(0, 4); idx = $urandom_range(0, 7); d = $urandom; be = 4'($urandom);
      case (op)
        0: begin
          do_req(1'b1, 32'h8000_0000 + 32'(idx * 4), d, be, lat, rd);
          for (int b = 0; b < 4; b++) if (!be[b]) exp_mem[idx][8*b +: 8] = d[8*b +: 8];
        end
        1: begin
          do_req(1'b0, 32'h8000_0000 + 32'(idx * 4), 32'h0, 4'h0, lat, rd);
          chk("mix_ram_rd", rd, exp_mem[idx]);
        end
        2: begin
          do_req(1'b1, UDATA, d, 4'hF, lat, rd);
          chk("mix_uwr_byte", 32'(last_wr_byte), 32'(d[7:0]));
        end
        3: begin
          uart_byte = d[7:0];
          do_req(1'b0, UDATA, 32'h0, 4'hF, lat, rd);
          chk("mix_urd", rd, {24'h0, d[7:0]});
        end
        default: begin
          do_req(1'b0, USTAT, 32'h0, 4'hF, lat, rd);
          chk("mix_stat_rx", rd >> 1, 32'(uart_dataready));
        end
      endcase
    end
    chk("overlap_viol", 32'(overlap_viol), 0);
    chk("drive_viol", 32'(drive_viol), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
